// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit scheduler: FSM states,
// requester identifiers, handshake PIDs and default sizing.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        WAIT_RDY  = 3'd2,
        WAIT_DONE = 3'd3,
        SEND_EOP  = 3'd4,
        WAIT_EOP  = 3'd5,
        DONE      = 3'd6
    } state_t;

    typedef enum logic {
        SRC_HS  = 1'b0,
        SRC_DAT = 1'b1
    } src_t;

    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    localparam int DEF_MAX_LEN    = 64;
    localparam int DEF_TMO_CYCLES = 32;

endpackage

// File: rtl/usb_tx_wdog.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags
// expiry once TMO_CYCLES cycles have elapsed without a clear.
module usb_tx_wdog #(
    parameter int TMO_CYCLES = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TMO_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && (cnt_q == CW'(TMO_CYCLES));

    // Holds at the expiry value; the owner is expected to clear on its abort transition.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/usb_tx_sched.sv
// Transmit scheduler: arbitrates HS/DAT requesters onto the single timer/encoder
// path and sequences start -> data_ready -> enc_done per byte, then EOP.
module usb_tx_sched
    import usb_tx_pkg::*;
#(
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int TMO_CYCLES = DEF_TMO_CYCLES,
    localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hs_req,
    input  logic [7:0]       hs_pid,
    output logic             hs_gnt,
    input  logic             dat_req,
    input  logic [LEN_W-1:0] dat_len,
    input  logic [7:0]       dat_byte,
    output logic             dat_gnt,
    output logic             dat_pop,
    output logic             tmr_start,
    input  logic             tmr_data_ready,
    input  logic             tmr_enc_done,
    output logic             enc_load,
    output logic [7:0]       enc_byte,
    output logic             enc_eop,
    input  logic             enc_eop_done,
    output logic             busy,
    output logic             tx_done,
    output logic             tx_err,
    output state_t           dbg_state
);

    // Requesters hold *_req until the single-cycle *_gnt pulse; pid/len/first byte
    // are sampled in that grant cycle, and later request changes are ignored.
    // Event inputs are single-cycle pulses acted on only in their waiting state.

    state_t           state_q, state_d;
    src_t             src_q, src_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic [7:0]       enc_byte_q, enc_byte_d;
    logic [7:0]       cur_byte;
    logic             wdog_clr, wdog_en, wdog_expire;

    assign cur_byte  = (src_q == SRC_HS) ? byte_q : dat_byte;
    assign busy      = (state_q != IDLE);
    assign enc_byte  = enc_byte_q;
    assign dbg_state = state_q;
    assign wdog_en   = (state_q == WAIT_RDY) || (state_q == WAIT_DONE) || (state_q == WAIT_EOP);
    assign wdog_clr  = (state_d != state_q);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        enc_byte_d = enc_byte_q;
        hs_gnt     = 1'b0;
        dat_gnt    = 1'b0;
        dat_pop    = 1'b0;
        tmr_start  = 1'b0;
        enc_load   = 1'b0;
        enc_eop    = 1'b0;
        tx_done    = 1'b0;
        tx_err     = 1'b0;
        case (state_q)
            IDLE: begin
                // Grants are held off while reset is asserted so no pulse escapes reset.
                if (rst && hs_req) begin
                    hs_gnt  = 1'b1;
                    src_d   = SRC_HS;
                    len_d   = LEN_W'(1);
                    cnt_d   = '0;
                    byte_d  = hs_pid;
                    state_d = ARM;
                end else if (rst && dat_req) begin
                    dat_gnt = 1'b1;
                    if (dat_len == '0) begin
                        tx_err = 1'b1;
                    end else begin
                        src_d   = SRC_DAT;
                        len_d   = (dat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : dat_len;
                        cnt_d   = '0;
                        byte_d  = dat_byte;
                        state_d = ARM;
                    end
                end
            end
            ARM: begin
                // Byte is registered here so it is already stable when enc_load pulses.
                tmr_start  = 1'b1;
                enc_byte_d = cur_byte;
                state_d    = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (tmr_data_ready) begin
                    enc_load = 1'b1;
                    dat_pop  = (src_q == SRC_DAT);
                    state_d  = WAIT_DONE;
                end else if (wdog_expire) begin
                    tx_err  = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (tmr_enc_done) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ((cnt_q + 1'b1) == len_q) ? SEND_EOP : ARM;
                end else if (wdog_expire) begin
                    tx_err  = 1'b1;
                    state_d = IDLE;
                end
            end
            SEND_EOP: begin
                enc_eop = 1'b1;
                state_d = WAIT_EOP;
            end
            WAIT_EOP: begin
                if (enc_eop_done) begin
                    state_d = DONE;
                end else if (wdog_expire) begin
                    tx_err  = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                tx_done = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            src_q      <= SRC_HS;
            len_q      <= '0;
            cnt_q      <= '0;
            byte_q     <= 8'h00;
            enc_byte_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            enc_byte_q <= enc_byte_d;
        end
    end

    usb_tx_wdog #(
        .TMO_CYCLES(TMO_CYCLES)
    ) u_wdog (
        .clk_i    (clk),
        .rst_ni   (rst),
        .clr_i    (wdog_clr),
        .en_i     (wdog_en),
        .expire_o (wdog_expire)
    );

endmodule
